nios_cpu_oci_mem_arbiter: RTL and testbench

Sequences and shares the Nios II on-chip-instrumentation (OCI) debug RAM between two requesters. The first is the JTAG debug path, driven by `jdo` and the `take_action_ocimem_*` strobes from the debug-slave sysclk logic. The second is the CPU-side Avalon debug memory slave. The block owns the JTAG address/data registers (`MonAReg`, `MonDReg`), arbitrates round-robin, and drives a single-port synchronous RAM with 1-cycle read latency.

---
 rtl/nios_cpu_oci_pkg.sv | 11 +
 rtl/nios_cpu_oci_mem_arbiter_if.sv | 22 ++
 rtl/nios_cpu_oci_rr_arb2.sv | 19 +
 rtl/nios_cpu_oci_mem_arbiter.sv | 103 ++++++++++
 tb/tb_nios_cpu_oci_mem_arbiter.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/nios_cpu_oci_pkg.sv
// nios_cpu_oci_pkg: shared types and jdo field positions for the OCI memory arbiter
// Contents: FSM state enum, jdo bit-field constants, data width, grant bit indices.
package nios_cpu_oci_pkg;
  typedef enum logic [2:0] {IDLE, AV_CMD, AV_DATA, JT_CMD, JT_DATA} state_t;
  localparam int JDO_ADDR_LSB = 3;
  localparam int JDO_RD_BIT = 17;
  localparam int JDO_WDATA_MSB = 34;
  localparam int OCI_DATA_W = 32;
  localparam int GNT_AV = 0;
  localparam int GNT_JT = 1;
endpackage

// File: rtl/nios_cpu_oci_mem_arbiter_if.sv
// nios_cpu_oci_mem_arbiter_if: Avalon debug-memory slave bus
// Signals: av_address/av_read/av_write/av_writedata/av_byteenable from the master,
// av_waitrequest/av_readdata back to it. The slave modport is the arbiter side.
interface nios_cpu_oci_mem_arbiter_if
  import nios_cpu_oci_pkg::*;
#(parameter int ADDR_W = 8) ();
  logic [ADDR_W-1:0] av_address;
  logic av_read;
  logic av_write;
  logic [OCI_DATA_W-1:0] av_writedata;
  logic [3:0] av_byteenable;
  logic av_waitrequest;
  logic [OCI_DATA_W-1:0] av_readdata;
  modport master (
    output av_address, av_read, av_write, av_writedata, av_byteenable,
    input av_waitrequest, av_readdata
  );
  modport slave (
    input av_address, av_read, av_write, av_writedata, av_byteenable,
    output av_waitrequest, av_readdata
  );
endinterface

// File: rtl/nios_cpu_oci_rr_arb2.sv
// nios_cpu_oci_rr_arb2: two-way round-robin arbiter
// Ports: clk, reset (sync, active-high); req[1:0] (bit 0 Avalon, bit 1 JTAG);
// update commits the current grant as the last one; grant[1:0] is one-hot or zero.
module nios_cpu_oci_rr_arb2
  import nios_cpu_oci_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic [1:0] req,
  input  logic update,
  output logic [1:0] grant
);
  logic last_jt;
  // On a tie the side not served last wins; starting at JTAG lets Avalon win the first tie.
  always_comb grant = &req ? (last_jt ? 2'b01 : 2'b10) : req;
  always_ff @(posedge clk)
    if (reset) last_jt <= 1'b1;
    else if (update) last_jt <= grant[GNT_JT];
endmodule

// File: rtl/nios_cpu_oci_mem_arbiter.sv
// nios_cpu_oci_mem_arbiter: shares the OCI debug RAM between the JTAG debug path and the Avalon slave
// Ports: clk, reset (sync, active-high); jdo + take_*_ocimem_* strobes from the JTAG side;
// MonDReg (JTAG read result), jtag_busy, jtag_overrun (sticky dropped-strobe flag);
// av (Avalon slave modport); ram_addr/ram_wren/ram_byteen/ram_wdata to the RAM, ram_rdata back (1-cycle latency).
module nios_cpu_oci_mem_arbiter
  import nios_cpu_oci_pkg::*;
#(parameter int ADDR_W = 8) (
  input  logic clk,
  input  logic reset,
  input  logic [37:0] jdo,
  input  logic take_action_ocimem_a,
  input  logic take_action_ocimem_b,
  input  logic take_no_action_ocimem_a,
  output logic [OCI_DATA_W-1:0] MonDReg,
  output logic jtag_busy,
  output logic jtag_overrun,
  nios_cpu_oci_mem_arbiter_if.slave av,
  output logic [ADDR_W-1:0] ram_addr,
  output logic ram_wren,
  output logic [3:0] ram_byteen,
  output logic [OCI_DATA_W-1:0] ram_wdata,
  input  logic [OCI_DATA_W-1:0] ram_rdata
);
  state_t state;
  logic [ADDR_W-1:0] MonAReg;
  logic [OCI_DATA_W-1:0] jt_wdata;
  logic [1:0] grant;
  logic jt_wr, jt_inc, av_rd, wren_q, av_req, av_done, strobe, unused_jdo;
  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};
  assign av_req = av.av_read | av.av_write;
  assign av_done = state == AV_DATA || (state == AV_CMD && !av_rd);
  // Holding waitrequest through reset guarantees an aborted transfer never looks completed.
  assign av.av_waitrequest = av_req & (reset | !av_done);
  assign av.av_readdata = state == AV_DATA ? ram_rdata : '0;
  // A reset landing on the command cycle must keep the write out of the RAM.
  assign ram_wren = wren_q & ~reset;
  assign strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  // In IDLE jtag_busy can only mean "pending", since the slot is freed before returning there.
  nios_cpu_oci_rr_arb2 u_arb (
    .clk(clk),
    .reset(reset),
    .req({jtag_busy, av_req}),
    .update(state == IDLE && |grant),
    .grant(grant)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      MonAReg <= '0;
      MonDReg <= '0;
      jtag_busy <= 1'b0;
      jtag_overrun <= 1'b0;
      jt_wr <= 1'b0;
      jt_inc <= 1'b0;
      jt_wdata <= '0;
      av_rd <= 1'b0;
      ram_addr <= '0;
      wren_q <= 1'b0;
      ram_byteen <= '0;
      ram_wdata <= '0;
    end else begin
      wren_q <= 1'b0;
      if (strobe && jtag_busy) jtag_overrun <= 1'b1;
      else if (strobe) begin
        if (take_action_ocimem_a) MonAReg <= jdo[ADDR_W+JDO_ADDR_LSB-1:JDO_ADDR_LSB];
        jtag_busy <= !take_action_ocimem_a || jdo[JDO_RD_BIT];
        jt_wr <= !take_action_ocimem_a && take_action_ocimem_b;
        jt_inc <= !take_action_ocimem_a;
        jt_wdata <= jdo[JDO_WDATA_MSB:JDO_ADDR_LSB];
      end
      case (state)
        IDLE:
          if (grant[GNT_AV]) begin
            state <= AV_CMD;
            av_rd <= av.av_read;
            ram_addr <= av.av_address;
            wren_q <= !av.av_read;
            ram_byteen <= av.av_byteenable;
            ram_wdata <= av.av_writedata;
          end else if (grant[GNT_JT]) begin
            state <= JT_CMD;
            ram_addr <= MonAReg;
            wren_q <= jt_wr;
            ram_byteen <= 4'hF;
            ram_wdata <= jt_wdata;
          end
        AV_CMD: state <= av_rd ? AV_DATA : IDLE;
        AV_DATA: state <= IDLE;
        JT_CMD: begin
          if (jt_inc) MonAReg <= MonAReg + ADDR_W'(1);
          if (jt_wr) jtag_busy <= 1'b0;
          state <= jt_wr ? IDLE : JT_DATA;
        end
        JT_DATA: begin
          MonDReg <= ram_rdata;
          jtag_busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nios_cpu_oci_mem_arbiter.sv
// tb_nios_cpu_oci_mem_arbiter: self-checking bench with a byte-enabled RAM model
module tb_nios_cpu_oci_mem_arbiter;
  typedef struct {
    logic [7:0] addr;
    logic [31:0] wdata;
    logic [3:0] be;
    logic [31:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [37:0] jdo = '0;
  logic take_action_ocimem_a = 1'b0;
  logic take_action_ocimem_b = 1'b0;
  logic take_no_action_ocimem_a = 1'b0;
  logic [31:0] MonDReg;
  logic jtag_busy, jtag_overrun;
  logic [7:0] ram_addr;
  logic ram_wren;
  logic [3:0] ram_byteen;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic [31:0] mem [256] = '{default: '0};
  int errs = 0;
  int checks = 0;
  vec_t vecs [7];
  nios_cpu_oci_mem_arbiter_if #(.ADDR_W(8)) av_bus ();
  nios_cpu_oci_mem_arbiter #(.ADDR_W(8)) dut (
    .clk(clk),
    .reset(reset),
    .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .MonDReg(MonDReg),
    .jtag_busy(jtag_busy),
    .jtag_overrun(jtag_overrun),
    .av(av_bus),
    .ram_addr(ram_addr),
    .ram_wren(ram_wren),
    .ram_byteen(ram_byteen),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (ram_wren)
      for (int i = 0; i < 4; i++)
        if (ram_byteen[i]) mem[ram_addr][8*i+:8] <= ram_wdata[8*i+:8];
    ram_rdata <= mem[ram_addr];
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic av_xfer(input logic rd, input logic [7:0] a, input logic [31:0] d,
                         input logic [3:0] be, output int lat, output logic [31:0] q);
    av_bus.av_address = a;
    av_bus.av_writedata = d;
    av_bus.av_byteenable = be;
    av_bus.av_read = rd;
    av_bus.av_write = !rd;
    lat = 0;
    q = '0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!av_bus.av_waitrequest) begin
        q = av_bus.av_readdata;
        break;
      end
      lat++;
      @(posedge clk);
      #1;
    end
    tick(1);
    av_bus.av_read = 1'b0;
    av_bus.av_write = 1'b0;
  endtask
  task automatic jt_pulse(input int kind, input logic [37:0] j);
    jdo = j;
    take_action_ocimem_a = kind == 0;
    take_action_ocimem_b = kind == 1;
    take_no_action_ocimem_a = kind == 2;
    tick(1);
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
  endtask
  function automatic logic [37:0] jaddr(input logic [7:0] a, input logic rd);
    return {20'b0, rd, 6'b0, a, 3'b0};
  endfunction
  function automatic logic [37:0] jdata(input logic [31:0] d);
    return {3'b0, d, 3'b0};
  endfunction
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int lat;
    logic [31:0] q;
    logic exp_wait [9];
    vecs[0] = '{8'h10, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF};
    vecs[1] = '{8'h11, 32'h11223344, 4'hF, 32'h11223344};
    vecs[2] = '{8'h11, 32'hAABBCCDD, 4'h3, 32'h1122CCDD};
    vecs[3] = '{8'h11, 32'h99000000, 4'h8, 32'h9922CCDD};
    vecs[4] = '{8'h05, 32'hA5A5A5A5, 4'hF, 32'hA5A5A5A5};
    vecs[5] = '{8'hFF, 32'h0BADF00D, 4'hF, 32'h0BADF00D};
    vecs[6] = '{8'h12, 32'h12345678, 4'h0, 32'h00000000};
    exp_wait = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    av_bus.av_address = '0;
    av_bus.av_writedata = '0;
    av_bus.av_byteenable = '0;
    av_bus.av_read = 1'b1;
    av_bus.av_write = 1'b0;
    take_no_action_ocimem_a = 1'b1;
    @(negedge clk);
    chk("wait_in_reset", av_bus.av_waitrequest, 1);
    tick(2);
    av_bus.av_read = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", jtag_busy, 0);
    chk("rst_overrun", jtag_overrun, 0);
    chk("rst_mond", MonDReg, 0);
    chk("rst_mona", dut.MonAReg, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wren", ram_wren, 0);
    chk("rst_ram_byteen", ram_byteen, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_readdata", av_bus.av_readdata, 0);
    chk("rst_wait", av_bus.av_waitrequest, 0);
    tick(1);
    for (int v = 0; v < 7; v++) begin
      av_xfer(1'b0, vecs[v].addr, vecs[v].wdata, vecs[v].be, lat, q);
      chk($sformatf("vec%0d_wr_lat", v), lat, 1);
      av_xfer(1'b1, vecs[v].addr, '0, 4'hF, lat, q);
      chk($sformatf("vec%0d_rd_lat", v), lat, 2);
      chk($sformatf("vec%0d_rd_data", v), q, vecs[v].exp);
    end
    jt_pulse(0, jaddr(8'hFF, 1'b0));
    chk("lda_busy", jtag_busy, 0);
    chk("lda_mona", dut.MonAReg, 32'hFF);
    jt_pulse(1, jdata(32'h12345678));
    chk("jwr_busy_t1", jtag_busy, 1);
    tick(2);
    chk("jwr_busy_t3", jtag_busy, 0);
    tick(2);
    jt_pulse(1, jdata(32'h9ABCDEF0));
    tick(4);
    chk("jwr_ram_ff", mem[8'hFF], 32'h12345678);
    chk("jwr_ram_00", mem[8'h00], 32'h9ABCDEF0);
    chk("jwr_mona_wrap", dut.MonAReg, 32'h01);
    av_bus.av_address = 8'h10;
    av_bus.av_byteenable = 4'hF;
    av_bus.av_read = 1'b1;
    jdo = jaddr(8'h11, 1'b1);
    take_action_ocimem_a = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      chk($sformatf("arb_wait_c%0d", c), av_bus.av_waitrequest, exp_wait[c]);
      if (!exp_wait[c]) chk($sformatf("arb_rdata_c%0d", c), av_bus.av_readdata, 32'hDEADBEEF);
      if (c == 5) chk("arb_busy_c5", jtag_busy, 1);
      if (c == 6) begin
        chk("arb_mond_c6", MonDReg, 32'h9922CCDD);
        chk("arb_busy_c6", jtag_busy, 0);
      end
      tick(1);
      take_action_ocimem_a = 1'b0;
    end
    av_bus.av_read = 1'b0;
    chk("arb_mona", dut.MonAReg, 32'h11);
    tick(1);
    jt_pulse(2, '0);
    tick(1);
    chk("ovr_before", jtag_overrun, 0);
    jt_pulse(2, '0);
    chk("ovr_set", jtag_overrun, 1);
    chk("ovr_busy_t3", jtag_busy, 1);
    tick(1);
    chk("ovr_busy_t4", jtag_busy, 0);
    chk("ovr_mona_once", dut.MonAReg, 32'h12);
    tick(5);
    chk("ovr_sticky", jtag_overrun, 1);
    jt_pulse(0, jaddr(8'h05, 1'b1));
    tick(2);
    chk("rda_busy_t3", jtag_busy, 1);
    chk("rda_mond_t3", MonDReg, 32'h9922CCDD);
    tick(1);
    chk("rda_mond_t4", MonDReg, 32'hA5A5A5A5);
    chk("rda_busy_t4", jtag_busy, 0);
    chk("rda_mona", dut.MonAReg, 32'h05);
    chk("rda_ovr_kept", jtag_overrun, 1);
    tick(1);
    av_bus.av_address = 8'h20;
    av_bus.av_writedata = 32'h55AA55AA;
    av_bus.av_byteenable = 4'hF;
    av_bus.av_write = 1'b1;
    tick(1);
    chk("abort_wren_cmd", ram_wren, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_wren_in_rst", ram_wren, 0);
    chk("abort_wait_in_rst", av_bus.av_waitrequest, 1);
    tick(1);
    reset = 1'b0;
    av_bus.av_write = 1'b0;
    @(negedge clk);
    chk("abort_wren", ram_wren, 0);
    chk("abort_addr", ram_addr, 0);
    chk("abort_byteen", ram_byteen, 0);
    chk("abort_wdata", ram_wdata, 0);
    chk("abort_mond", MonDReg, 0);
    chk("abort_mona", dut.MonAReg, 0);
    chk("abort_busy", jtag_busy, 0);
    chk("abort_overrun", jtag_overrun, 0);
    chk("abort_rdata", av_bus.av_readdata, 0);
    tick(2);
    chk("abort_ram20", mem[8'h20], 0);
    av_xfer(1'b1, 8'h20, '0, 4'hF, lat, q);
    chk("abort_rd_lat", lat, 2);
    chk("abort_rd_data", q, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
